// File: rtl/gpio_reg_master.sv
// gpio_reg_master: register-bus initiator that turns valid/ready commands into
// single-cycle wr_en/rd_en strobes on the GPIO register bank's simple bus.
// Ports:
//   clk, rst_n                            - clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/addr/data  - command port (00 rd, 01 wr, 10 set, 11 clr)
//   rsp_valid/rsp_ready/rsp_data/rsp_err  - response port, one response per command
//   bus_wr_en/bus_rd_en/bus_addr/bus_wr_data/bus_rd_data - register bus
// Latency: read/write respond 1 cycle after accept, RMW 2 cycles, errors at once.
// Backpressure: one command outstanding; cmd_ready is low until the response
// handshakes, and rsp_data/rsp_err hold while rsp_valid waits on rsp_ready.
// Build option: define GPIO_RMW_EN to build the set-bits/clear-bits RMW path;
// without it, ops 10/11 are rejected as error commands.

module gpio_reg_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_wr_en,
  output logic              bus_rd_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd5;
`ifdef GPIO_RMW_EN
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
`endif

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIR  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(8);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef GPIO_RMW_EN
  // Mask and set/clear flavour are held across the read phase of an RMW.
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              clr_q, clr_d;
  logic [DATA_W-1:0] rmw_new;
`endif

  logic addr_ok;
  logic cmd_err;

  always_comb begin
    addr_ok = (cmd_addr == A_DATA) || (cmd_addr == A_DIR) || (cmd_addr == A_IN);
    cmd_err = !addr_ok || ((cmd_op != OP_RD) && (cmd_addr == A_IN));
`ifndef GPIO_RMW_EN
    // Set/clear ops have no datapath in this build.
    cmd_err = cmd_err || cmd_op[1];
`endif
  end

`ifdef GPIO_RMW_EN
  always_comb begin
    rmw_new = clr_q ? (bus_rd_data & ~mask_q) : (bus_rd_data | mask_q);
  end
`endif

  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
`ifdef GPIO_RMW_EN
    mask_d        = mask_q;
    clr_d         = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_err) begin
            // Rejected: straight to response, bus outputs untouched.
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end else begin
            rsp_err_d  = 1'b0;
            bus_addr_d = cmd_addr;
            case (cmd_op)
              OP_RD: state_d = S_READ;
              OP_WR: begin
                bus_wr_data_d = cmd_data;
                rsp_data_d    = cmd_data;
                state_d       = S_WRITE;
              end
              default: begin
`ifdef GPIO_RMW_EN
                mask_d  = cmd_data;
                clr_d   = cmd_op[0];
                state_d = S_RMW_RD;
`else
                state_d = S_RESP;
`endif
              end
            endcase
          end
        end
      end
      S_WRITE: state_d = S_RESP;
      S_READ: begin
        rsp_data_d = bus_rd_data;
        state_d    = S_RESP;
      end
`ifdef GPIO_RMW_EN
      S_RMW_RD: begin
        bus_wr_data_d = rmw_new;
        rsp_data_d    = rmw_new;
        state_d       = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
`ifdef GPIO_RMW_EN
      mask_q        <= '0;
      clr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
`ifdef GPIO_RMW_EN
      mask_q        <= mask_d;
      clr_q         <= clr_d;
`endif
    end
  end

  // Strobes decode directly from the state flop, so reset drops them at once
  // and the two can never be high together.
  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
`ifdef GPIO_RMW_EN
  assign bus_wr_en   = (state_q == S_WRITE) || (state_q == S_RMW_WR);
  assign bus_rd_en   = (state_q == S_READ)  || (state_q == S_RMW_RD);
`else
  assign bus_wr_en   = (state_q == S_WRITE);
  assign bus_rd_en   = (state_q == S_READ);
`endif
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule
